// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction
// fetch port (I) and the load/store port (D). One transaction is in flight at a
// time; contention is settled round-robin and each response returns to the
// port that issued the request after a fixed read latency.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_W-1:0]     i_rsp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_W-1:0]     d_req_wdata,
    input  logic [DATA_W/8-1:0]   d_req_wstrb,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_data,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int         STRB_W = DATA_W / 8;
    localparam logic [2:0] LAT_C  = 3'(LATENCY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic                owner;       // 0 = I, 1 = D
    logic                is_wr;
    logic                last_grant;  // 0 = I, 1 = D
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                grant_i;
    logic                grant_d;
    logic                accept;

    // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_i = (state == IDLE) && i_req_valid && (!d_req_valid || last_grant);
        grant_d = (state == IDLE) && d_req_valid && (!i_req_valid || !last_grant);
        accept  = grant_i || grant_d;
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign busy        = (state != IDLE);

    // RAM drive: live from the granted request on the accept cycle, otherwise hold
    // the last driven address/data so the RAM pins do not toggle needlessly.
    always_comb begin
        mem_en    = accept;
        mem_we    = (grant_d && d_req_we) ? d_req_wstrb : {STRB_W{1'b0}};
        mem_addr  = grant_i ? i_req_addr : (grant_d ? d_req_addr : addr_q);
        mem_wdata = grant_d ? d_req_wdata : wdata_q;
    end

    // Transaction FSM: accept in IDLE, count out the read latency in WAIT, then
    // register the response for the owning port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            owner       <= 1'b0;
            is_wr       <= 1'b0;
            last_grant  <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            d_rsp_data  <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= mem_addr;
                        wdata_q    <= mem_wdata;
                        owner      <= grant_d;
                        is_wr      <= grant_d && d_req_we;
                        last_grant <= grant_d;
                        cnt        <= 3'd1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT_C) begin
                        // Write acks carry zero data rather than whatever the RAM drives.
                        if (owner) begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_data  <= is_wr ? '0 : mem_rdata;
                        end else begin
                            i_rsp_valid <= 1'b1;
                            i_rsp_data  <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port synchronous instruction/data RAM between the core's instruction-fetch port (I) and load/store port (D).
- Accepts one request at a time over valid/ready handshakes and drives the RAM for exactly one cycle.
- Waits a fixed read latency, then returns a registered response to the requester that issued the request.
- Contention is resolved round-robin, so neither fetch nor load/store can starve.
- Sits between the core and the RAM inside Top.

Parameters:
ADDR_W, 32, byte address width of requests and of mem_addr
DATA_W, 32, data width; byte strobes are DATA_W/8 wide
LATENCY, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
i_req_valid  input  1  fetch request valid
i_req_ready  output  1  fetch request accepted this cycle
i_req_addr  input  ADDR_W  fetch address
i_rsp_valid  output  1  fetch response valid (1-cycle pulse)
i_rsp_data  output  DATA_W  fetched word
d_req_valid  input  1  data request valid
d_req_ready  output  1  data request accepted this cycle
d_req_addr  input  ADDR_W  data address
d_req_we  input  1  1 = write, 0 = read
d_req_wdata  input  DATA_W  write data
d_req_wstrb  input  DATA_W/8  write byte strobes
d_rsp_valid  output  1  data response/ack valid (1-cycle pulse)
d_rsp_data  output  DATA_W  read data; 0 for write acks
mem_en  output  1  RAM access strobe
mem_we  output  DATA_W/8  RAM byte write enables
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid LATENCY cycles after mem_en
busy  output  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, wait counter = 0, owner = I, last_grant = D.
  - All rsp_valid, rsp_data and busy are 0.
  - Reset wins over every other event; an in-flight transaction is dropped with no response.
- FSM states: IDLE and WAIT.
- IDLE, grant selection (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - At most one of i_req_ready/d_req_ready is high; both are 0 outside IDLE.
- IDLE, accept cycle (valid & ready):
  - mem_en = 1; mem_addr, mem_wdata and mem_we are driven combinationally from the granted request.
  - mem_we = d_req_wstrb for a D write; 0 for a D read or any I request.
  - Register owner and whether the access is a write; last_grant <= granted requester; counter <= 1; go to WAIT.
- Outside accept cycles, mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold their last driven value.
- WAIT:
  - Counter increments each cycle.
  - On the cycle the counter equals LATENCY, capture mem_rdata (or 0 for a write) into the owner's rsp_data, set the owner's rsp_valid for the next cycle, and go to IDLE.
- Timing:
  - Latency from accept edge to rsp_valid is LATENCY+1 cycles.
  - Back-to-back: the cycle rsp_valid is high, state is IDLE, so a new request may be accepted in that same cycle.
  - Throughput is one transaction per LATENCY+1 cycles.
- Responses:
  - rsp_valid is a single-cycle pulse with no backpressure; requesters must sink it.
  - rsp_data holds its value until the next response to that port.
- A requester may hold valid through its own pending response; it is re-arbitrated normally.
- valid deasserted before ready is simply ignored (no accept).
- A D write with wstrb = 0 is still issued (mem_en = 1, mem_we = 0) and acked.
- Request inputs are not registered, so requesters must hold addr/data stable while valid is high and ready is low.

Test Plan:
- Reset then I-only read addr 0x10, RAM word 0xDEADBEEF, LATENCY = 1 -> i_req_ready high in cycle 0, mem_en 1 cycle, i_rsp_valid at cycle 2 with 0xDEADBEEF, d_rsp_valid stays 0.
- I and D both valid continuously from reset -> grants alternate I, D, I, D; each accepted 2 cycles apart; responses routed to the matching port.
- D write addr 0x20, wdata 0x11223344, wstrb 0b0011, then D read 0x20 (RAM initialised to 0xAABBCCDD) -> mem_we = 0011 on the write cycle; write ack with data 0; read returns 0xAABB3344.
- LATENCY = 3, single D read -> d_rsp_valid exactly 4 cycles after accept; busy high for 3 cycles; mem_en high only in the accept cycle.
- rst_n pulled low while in WAIT, then released -> no rsp_valid emitted; busy = 0; first contended grant after release goes to I.
- New I request presented the cycle d_rsp_valid pulses -> accepted that same cycle (zero-bubble turnaround).
